// File: rtl/dma_pkg.sv
// Shared constants and types for the row DMA masters (reader and writer).
// Holds the default geometry, the reader FSM encoding and a counter-width helper.
package dma_pkg;

   // Default row geometry, shared with the row writer.
   localparam int unsigned DMA_NUM_BLOCKS  = 16;
   localparam int unsigned DMA_BLOCK_SIZE  = 4;
   localparam int unsigned DMA_ADDR_WIDTH  = 16;
   localparam int unsigned DMA_RAM_LATENCY = 1;

   localparam int unsigned ROW_WIDTH = DMA_NUM_BLOCKS * DMA_BLOCK_SIZE;

   // Reader FSM encoding.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } dma_state_t;

   // Width of a counter that must be able to hold the value n.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/dma_row_assembler.sv
// Row assembler for the read DMA.
// Delays the issue strobe by RAM_LATENCY cycles so it lines up with ram_data,
// then drops each returning word into the shadow row at the next block index.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear        restart a row (start accepted)
//   issue        a RAM read was issued this cycle (the reader's ram_enable)
//   ram_data     RAM read data
//   row_full_c   the final block of the row is arriving this cycle
//   row_c        shadow row with the current arriving block already merged in
module dma_row_assembler #(
   parameter int unsigned NUM_BLOCKS  = dma_pkg::DMA_NUM_BLOCKS,
   parameter int unsigned BLOCK_SIZE  = dma_pkg::DMA_BLOCK_SIZE,
   parameter int unsigned RAM_LATENCY = dma_pkg::DMA_RAM_LATENCY
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clear,
   input  logic                             issue,
   input  logic [BLOCK_SIZE-1:0]            ram_data,
   output logic                             row_full_c,
   output logic [NUM_BLOCKS*BLOCK_SIZE-1:0] row_c
);
   import dma_pkg::*;

   localparam int unsigned ROW_W = NUM_BLOCKS * BLOCK_SIZE;
   localparam int unsigned CNT_W = cnt_width(NUM_BLOCKS);

   logic [RAM_LATENCY-1:0] vpipe;
   logic [ROW_W-1:0]       shadow;
   logic [CNT_W-1:0]       rcv_cnt;
   logic                   valid_c;

   // Tail of the valid pipe marks the cycle ram_data carries an issued read.
   assign valid_c = vpipe[RAM_LATENCY-1];

   // Shadow row with the arriving block inserted at index rcv_cnt.
   always_comb begin
      row_c = shadow;
      for (int k = 0; k < int'(NUM_BLOCKS); k++) begin
         if (valid_c && (rcv_cnt == CNT_W'(k))) begin
            row_c[k*BLOCK_SIZE +: BLOCK_SIZE] = ram_data;
         end
      end
   end

   assign row_full_c = valid_c && (rcv_cnt == CNT_W'(NUM_BLOCKS - 1));

   // Valid pipe, shadow row and receive counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vpipe   <= '0;
         shadow  <= '0;
         rcv_cnt <= '0;
      end else begin
         vpipe[0] <= issue;
         for (int i = 1; i < int'(RAM_LATENCY); i++) begin
            vpipe[i] <= vpipe[i-1];
         end
         if (clear) begin
            shadow  <= '0;
            rcv_cnt <= '0;
         end else if (valid_c) begin
            shadow  <= row_c;
            rcv_cnt <= rcv_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/dma_row_reader.sv
// Read-side row DMA: fetches NUM_BLOCKS consecutive words from block RAM starting
// at base_addr, one read per cycle, and publishes them packed as one row.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        request a row fetch (only honoured while idle)
//   base_addr    first RAM address, captured on start acceptance
//   ram_enable   RAM access strobe
//   write        RAM write strobe, always 0 (read-only master)
//   address      RAM address (wraps modulo 2^ADDR_WIDTH)
//   ram_data     RAM read data, valid RAM_LATENCY cycles after its address
//   busy         high from start acceptance until done
//   done         one-cycle pulse, row_out updated in this cycle
//   row_out      last completed row, block k at [k*BLOCK_SIZE +: BLOCK_SIZE]
module dma_row_reader #(
   parameter int unsigned NUM_BLOCKS  = dma_pkg::DMA_NUM_BLOCKS,
   parameter int unsigned BLOCK_SIZE  = dma_pkg::DMA_BLOCK_SIZE,
   parameter int unsigned ADDR_WIDTH  = dma_pkg::DMA_ADDR_WIDTH,
   parameter int unsigned RAM_LATENCY = dma_pkg::DMA_RAM_LATENCY
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [ADDR_WIDTH-1:0]            base_addr,
   output logic                             ram_enable,
   output logic                             write,
   output logic [ADDR_WIDTH-1:0]            address,
   input  logic [BLOCK_SIZE-1:0]            ram_data,
   output logic                             busy,
   output logic                             done,
   output logic [NUM_BLOCKS*BLOCK_SIZE-1:0] row_out
);
   import dma_pkg::*;

   localparam int unsigned ROW_W = NUM_BLOCKS * BLOCK_SIZE;
   localparam int unsigned CNT_W = cnt_width(NUM_BLOCKS);

   dma_state_t            state;
   logic [CNT_W-1:0]      issue_cnt;
   logic [ADDR_WIDTH-1:0] base_q;
   logic                  accept_c;
   logic                  row_full_c;
   logic [ROW_W-1:0]      row_c;

   assign accept_c = (state == IDLE) && start;

   // Read-only master: never drives a write.
   assign write = 1'b0;

   dma_row_assembler #(
      .NUM_BLOCKS  (NUM_BLOCKS),
      .BLOCK_SIZE  (BLOCK_SIZE),
      .RAM_LATENCY (RAM_LATENCY)
   ) u_assembler (
      .clk        (clk),
      .rst        (rst),
      .clear      (accept_c),
      .issue      (ram_enable),
      .ram_data   (ram_data),
      .row_full_c (row_full_c),
      .row_c      (row_c)
   );

   // FSM with issue counter and address generation; all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         issue_cnt  <= '0;
         base_q     <= '0;
         ram_enable <= 1'b0;
         address    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         row_out    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // First read goes out in the cycle right after acceptance.
                  base_q     <= base_addr;
                  address    <= base_addr;
                  ram_enable <= 1'b1;
                  issue_cnt  <= CNT_W'(1);
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (issue_cnt == CNT_W'(NUM_BLOCKS)) begin
                  ram_enable <= 1'b0;
                  state      <= DRAIN;
               end else begin
                  address   <= base_q + ADDR_WIDTH'(issue_cnt);
                  issue_cnt <= issue_cnt + CNT_W'(1);
               end
            end
            DRAIN: begin
               // Publish in the same edge that captures the last block.
               if (row_full_c) begin
                  row_out <= row_c;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
